// File: rtl/writeback_stage_if.sv
// MEM-to-WB boundary bundle: stage controls, captured MEM fields and WB results.
// The master drives the MEM side; the slave is the writeback stage.
interface writeback_stage_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned INSTRET_WIDTH  = 64
);
  logic                      stall_i;
  logic                      flush_i;
  logic                      MEM_valid_i;
  logic [DATA_WIDTH-1:0]     MEM_instruction_i;
  logic                      MEM_RegWrite_i;
  logic                      MEM_MemRead_i;
  logic                      MEM_MemWrite_i;
  logic [1:0]                MEM_WBSel_i;
  logic [DATA_WIDTH-1:0]     MEM_addr_i;
  logic [DATA_WIDTH-1:0]     MEM_wr_data_i;
  logic [DATA_WIDTH-1:0]     MEM_pc_plus4_i;
  logic [DATA_WIDTH-1:0]     MEM_rd_data_i;

  logic                      WB_valid_o;
  logic                      WB_RegWrite_o;
  logic [REG_ADDR_WIDTH-1:0] WB_rd_addr_o;
  logic [DATA_WIDTH-1:0]     WB_rf_wr_data_o;
  logic                      WB_MemWrite_o;
  logic [DATA_WIDTH-1:0]     WB_addr_o;
  logic [DATA_WIDTH-1:0]     WB_wr_data_o;
  logic                      WB_load_misalign_o;
  logic [INSTRET_WIDTH-1:0]  WB_instret_o;

  modport master (
    output stall_i, flush_i, MEM_valid_i, MEM_instruction_i, MEM_RegWrite_i, MEM_MemRead_i,
           MEM_MemWrite_i, MEM_WBSel_i, MEM_addr_i, MEM_wr_data_i, MEM_pc_plus4_i,
           MEM_rd_data_i,
    input  WB_valid_o, WB_RegWrite_o, WB_rd_addr_o, WB_rf_wr_data_o, WB_MemWrite_o,
           WB_addr_o, WB_wr_data_o, WB_load_misalign_o, WB_instret_o
  );

  modport slave (
    input  stall_i, flush_i, MEM_valid_i, MEM_instruction_i, MEM_RegWrite_i, MEM_MemRead_i,
           MEM_MemWrite_i, MEM_WBSel_i, MEM_addr_i, MEM_wr_data_i, MEM_pc_plus4_i,
           MEM_rd_data_i,
    output WB_valid_o, WB_RegWrite_o, WB_rd_addr_o, WB_rf_wr_data_o, WB_MemWrite_o,
           WB_addr_o, WB_wr_data_o, WB_load_misalign_o, WB_instret_o
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, load alignment/extension, write-back select and retire counter.
// All WB outputs are decoded from the register only; no MEM-to-WB combinational path.
module writeback_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned INSTRET_WIDTH  = 64
) (
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave bus
);

  logic                     valid_q;
  logic                     regwrite_q;
  logic                     memread_q;
  logic                     memwrite_q;
  logic [1:0]               wbsel_q;
  logic [DATA_WIDTH-1:0]    instr_q;
  logic [DATA_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic [DATA_WIDTH-1:0]    pc_plus4_q;
  logic [DATA_WIDTH-1:0]    rd_data_q;
  logic [INSTRET_WIDTH-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      wbsel_q    <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      pc_plus4_q <= '0;
      rd_data_q  <= '0;
    end else if (!bus.stall_i) begin
      valid_q    <= bus.MEM_valid_i;
      regwrite_q <= bus.MEM_RegWrite_i;
      memread_q  <= bus.MEM_MemRead_i;
      memwrite_q <= bus.MEM_MemWrite_i;
      wbsel_q    <= bus.MEM_WBSel_i;
      instr_q    <= bus.MEM_instruction_i;
      addr_q     <= bus.MEM_addr_i;
      wr_data_q  <= bus.MEM_wr_data_i;
      pc_plus4_q <= bus.MEM_pc_plus4_i;
      rd_data_q  <= bus.MEM_rd_data_i;
    end
  end

  logic [2:0]                funct3;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]                byte_v;
  logic [15:0]               half_v;
  logic [DATA_WIDTH-1:0]     load_data;
  logic [DATA_WIDTH-1:0]     rf_data;
  logic                      misalign;
  logic                      unused_instr;

  assign funct3       = instr_q[14:12];
  assign rd_addr      = instr_q[7 +: REG_ADDR_WIDTH];
  assign unused_instr = ^{instr_q[DATA_WIDTH-1:15], instr_q[6:0]};

  always_comb begin
    byte_v = rd_data_q[7:0];
    unique case (addr_q[1:0])
      2'd0: byte_v = rd_data_q[7:0];
      2'd1: byte_v = rd_data_q[15:8];
      2'd2: byte_v = rd_data_q[23:16];
      2'd3: byte_v = rd_data_q[31:24];
      default: byte_v = rd_data_q[7:0];
    endcase
    half_v = addr_q[1] ? rd_data_q[31:16] : rd_data_q[15:0];
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      3'b000: load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      3'b001: load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      3'b010: load_data = rd_data_q;
      3'b100: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      3'b101: load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    if (valid_q && memread_q) begin
      if ((funct3 == 3'b001 || funct3 == 3'b101) && addr_q[0]) misalign = 1'b1;
      if (funct3 == 3'b010 && addr_q[1:0] != 2'b00) misalign = 1'b1;
    end
  end

  // Driven regardless of RegWrite so the value can still be forwarded.
  always_comb begin
    rf_data = '0;
    unique case (wbsel_q)
      2'b00: rf_data = addr_q;
      2'b01: rf_data = load_data;
      2'b10: rf_data = pc_plus4_q;
      default: rf_data = '0;
    endcase
  end

  // An instruction retires as it leaves WB, so a stalled one counts exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (valid_q && !bus.stall_i && !misalign) begin
      instret_q <= instret_q + INSTRET_WIDTH'(1);
    end
  end

  assign bus.WB_valid_o         = valid_q;
  assign bus.WB_RegWrite_o      = regwrite_q & valid_q & (rd_addr != '0) & ~misalign;
  assign bus.WB_rd_addr_o       = rd_addr;
  assign bus.WB_rf_wr_data_o    = rf_data;
  assign bus.WB_MemWrite_o      = memwrite_q & valid_q;
  assign bus.WB_addr_o          = addr_q;
  assign bus.WB_wr_data_o       = wr_data_q;
  assign bus.WB_load_misalign_o = misalign;
  assign bus.WB_instret_o       = instret_q;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Sits directly downstream of memory_stage.
- Holds the MEM/WB pipeline register and performs load alignment and sign/zero extension.
- Selects the register-file write-back source and drives the register-file write port.
- Returns the registered store signals (WB_MemWrite/WB_addr/WB_wr_data) that data memory uses for its deferred write.
- Maintains a 64-bit retired-instruction counter.

Parameters:
DATA_WIDTH, 32 (from defines), datapath width
REG_ADDR_WIDTH, 5, register index width
INSTRET_WIDTH, 64, retire counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  hold MEM/WB register
flush_i  input  1  insert bubble into MEM/WB register
MEM_valid_i  input  1  MEM stage holds a real instruction
MEM_instruction_i  input  DATA_WIDTH  instruction in MEM (rd=[11:7], funct3=[14:12])
MEM_RegWrite_i  input  1  instruction writes rd
MEM_MemRead_i  input  1  load
MEM_MemWrite_i  input  1  store
MEM_WBSel_i  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (writes 0)
MEM_addr_i  input  DATA_WIDTH  ALU result / memory address
MEM_wr_data_i  input  DATA_WIDTH  store data
MEM_pc_plus4_i  input  DATA_WIDTH  PC+4
MEM_rd_data_i  input  DATA_WIDTH  raw aligned word from data memory, valid combinationally in MEM cycle
WB_valid_o  output  1  WB holds a real instruction
WB_RegWrite_o  output  1  register-file write enable
WB_rd_addr_o  output  REG_ADDR_WIDTH  destination register
WB_rf_wr_data_o  output  DATA_WIDTH  register-file write data / forwarding value
WB_MemWrite_o  output  1  deferred store enable to data memory
WB_addr_o  output  DATA_WIDTH  deferred store address
WB_wr_data_o  output  DATA_WIDTH  deferred store data
WB_load_misalign_o  output  1  misaligned load in WB
WB_instret_o  output  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Register update priority per rising edge:
  - rst: all fields 0.
  - flush_i: bubble (valid=0, RegWrite=0, MemWrite=0, MemRead=0; other fields 0).
  - stall_i: hold all fields.
  - else: capture all MEM_* inputs.
- flush_i has priority over stall_i.
- Latency: MEM inputs appear on WB outputs one cycle later. All outputs are combinational from the register only; no MEM-to-WB combinational path.
- Reset values: every output is 0, including WB_instret_o.
- Valid gating:
  - WB_MemWrite_o = q_MemWrite & q_valid.
  - WB_RegWrite_o = q_RegWrite & q_valid & (rd != 0) & ~WB_load_misalign_o.
  - WB_rd_addr_o, WB_addr_o, WB_wr_data_o pass the registered values through.
- Load extension (little endian, byte offset = q_addr[1:0]):
  - 000 LB: sign-extend byte at offset.
  - 001 LH: sign-extend halfword at offset[1] (offset 0 → bits 15:0, offset 2 → bits 31:16).
  - 010 LW: word unchanged.
  - 100 LBU: zero-extend byte at offset.
  - 101 LHU: zero-extend halfword at offset[1].
  - 011, 110, 111: load result 0.
- Misalignment: WB_load_misalign_o = q_valid & q_MemRead & ((LH/LHU & addr[0]) | (LW & addr[1:0]!=0)). Register write is suppressed when asserted.
- Write-back mux: WB_rf_wr_data_o is driven from WBSel even when RegWrite is 0 (used for forwarding).
- Retire counter:
  - Increments by 1 on an edge where q_valid=1, stall_i=0, rst=0 and WB_load_misalign_o=0.
  - A stalled WB instruction therefore counts once, on the cycle it leaves.
  - Wraps from all-ones to 0.
  - rst clears it.
  - flush_i does not block counting of the instruction currently in WB.
- Stall held in WB: register-file and store writes repeat with identical values. This is permitted and idempotent.
- Reset mid-stall or mid-flush: reset wins; the next cycle shows a bubble.

Test Plan:
1. LB then LBU, addr=0x103, MEM_rd_data_i=0x80FF_1234, rd=5 → WB cycle: WB_rf_wr_data_o=0xFFFF_FF80 then 0x0000_0080, WB_RegWrite_o=1, WB_rd_addr_o=5.
2. LH, addr=0x102, data=0x8001_7FFF → 0xFFFF_8001; LH, addr=0x101 → WB_load_misalign_o=1, WB_RegWrite_o=0, instret unchanged.
3. Store, MEM_MemWrite_i=1, addr=0x40, data=0xDEAD_BEEF → next cycle WB_MemWrite_o=1, WB_addr_o=0x40, WB_wr_data_o=0xDEAD_BEEF; same instruction with flush_i=1 → WB_MemWrite_o=0, WB_valid_o=0.
4. Stall 3 cycles with a valid ALU op (WBSel=00, addr=0x1234) in WB → outputs held 3 cycles; WB_instret_o increments by exactly 1, on release; stall_i and flush_i together → bubble.
5. Writes to rd=0 with RegWrite=1 → WB_RegWrite_o=0; WBSel=10, pc_plus4=0x2004 → WB_rf_wr_data_o=0x2004.
6. Counter forced near wrap (0xFFFF_FFFF_FFFF_FFFF) plus one retire → 0. Reset asserted during a valid load → all outputs 0 on the next cycle.
